// File: rtl/adder_accum_ctrl_if.sv
// Signal bundle between the accumulation controller and its environment:
// control, operand stream, external adder and result stream.
interface adder_accum_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] len;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic [WIDTH-1:0] result;
    logic             ovf;
    logic             carry;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    // Environment side: supplies control, operands, the adder and the sink.
    modport master (
        output start, abort, len, in_data, in_valid, add_sum, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin, result, ovf, carry, out_valid, busy
    );

    // Controller side.
    modport slave (
        input  start, abort, len, in_data, in_valid, add_sum, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin, result, ovf, carry, out_valid, busy
    );
endinterface

// File: rtl/adder_accum_ctrl.sv
// Burst accumulator that time-multiplexes one external combinational adder,
// feeding the running sum back on add_a and presenting sum plus sticky flags.
module adder_accum_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    adder_accum_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic [CNT_W-1:0] remaining_reg, remaining_next;
    logic             ovf_reg, ovf_next;
    logic             carry_reg, carry_next;

    logic             accum_sel;
    logic             in_fire;
    logic             add_ovf;

    assign accum_sel = (state_reg == ACCUM);
    assign in_fire   = accum_sel && bus.in_valid;

    // Signed overflow: operands agree in sign but the sum does not.
    assign add_ovf = (acc_reg[WIDTH-1] == bus.in_data[WIDTH-1]) &&
                     (bus.add_sum[WIDTH-1] != acc_reg[WIDTH-1]);

    // Operand B is forced to zero outside ACCUM so the adder sees a quiet input.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_add_b
            assign bus.add_b[gi] = bus.in_data[gi] & accum_sel;
        end
    endgenerate

    assign bus.add_a     = acc_reg;
    assign bus.add_cin   = 1'b0;
    assign bus.in_ready  = accum_sel;
    assign bus.out_valid = (state_reg == DONE);
    assign bus.busy      = (state_reg != IDLE);
    assign bus.result    = result_reg;
    assign bus.ovf       = ovf_reg;
    assign bus.carry     = carry_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            result_reg    <= '0;
            remaining_reg <= '0;
            ovf_reg       <= 1'b0;
            carry_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            result_reg    <= result_next;
            remaining_reg <= remaining_next;
            ovf_reg       <= ovf_next;
            carry_reg     <= carry_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        result_next    = result_reg;
        remaining_next = remaining_reg;
        ovf_next       = ovf_reg;
        carry_next     = carry_reg;

        if (bus.abort) begin
            state_next     = IDLE;
            acc_next       = '0;
            result_next    = '0;
            remaining_next = '0;
            ovf_next       = 1'b0;
            carry_next     = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        acc_next    = '0;
                        result_next = '0;
                        ovf_next    = 1'b0;
                        carry_next  = 1'b0;
                        if (bus.len != '0) begin
                            remaining_next = bus.len;
                            state_next     = ACCUM;
                        end else begin
                            remaining_next = '0;
                            state_next     = DONE;
                        end
                    end
                end
                ACCUM: begin
                    if (in_fire) begin
                        acc_next       = bus.add_sum;
                        remaining_next = remaining_reg - CNT_ONE;
                        carry_next     = carry_reg | bus.add_cout;
                        ovf_next       = ovf_reg | add_ovf;
                        // Capture the final sum so result only changes on burst completion.
                        if (remaining_reg == CNT_ONE) begin
                            result_next = bus.add_sum;
                            state_next  = DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/adder_accum_ctrl.md
Name: adder_accum_ctrl

Overview:
Sequencer that time-multiplexes one external 16-bit ripple adder (A, B, Cin -> Sum, Cout) to accumulate a burst of N operands. It is used for the DCNN accelerator's convolution window sums, for example 25 products for a 5x5 kernel. It latches a burst length on start, accepts operands over a valid/ready stream, and feeds the running sum back through the adder. It then presents the final sum and overflow flags on a valid/ready output.

Parameters:
WIDTH, 16, datapath width; must match the adder instance.
CNT_W, 8, burst-length counter width; max burst is 2^CNT_W - 1.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  begin burst; sampled only in IDLE
abort  in  1  synchronous cancel of the current burst
len  in  CNT_W  number of operands in the burst; latched on start
in_data  in  WIDTH  operand, two's complement
in_valid  in  1  operand valid
in_ready  out  1  controller accepts operand
add_a  out  WIDTH  to adder A: current accumulator
add_b  out  WIDTH  to adder B: in_data when in ACCUM, else 0
add_cin  out  1  to adder Cin; constant 0
add_sum  in  WIDTH  from adder Sum
add_cout  in  1  from adder Cout
result  out  WIDTH  final accumulated sum
ovf  out  1  sticky signed overflow for the burst
carry  out  1  sticky unsigned carry-out for the burst
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous and active-low.
- Reset values: state = IDLE; acc, remaining, result = 0; ovf, carry, in_ready, out_valid, busy = 0.
- The adder is purely combinational. add_a/add_b are driven combinationally from acc and in_data; add_sum is registered in the same cycle. add_cin is tied to 0.
- IDLE:
  - in_ready = 0.
  - start = 1 with len != 0: acc <= 0, remaining <= len, ovf/carry <= 0, go to ACCUM.
  - start = 1 with len == 0: acc <= 0, flags cleared, go to DONE (result 0).
  - start = 0: stay in IDLE.
- ACCUM:
  - in_ready = 1.
  - On in_valid && in_ready: acc <= add_sum and remaining <= remaining - 1.
  - carry |= add_cout.
  - ovf |= (acc[W-1] == in_data[W-1]) && (add_sum[W-1] != acc[W-1]).
  - Sum wraps modulo 2^16; no saturation.
  - When the accepted operand is the last one (remaining == 1), go to DONE.
  - in_valid low inserts stall cycles; acc and remaining hold.
- DONE:
  - out_valid = 1; result = acc, registered and stable while out_valid is high.
  - in_ready = 0; start is ignored.
  - out_ready = 1: out_valid drops next cycle, go to IDLE.
  - out_ready low holds all outputs.
- Latency: out_valid rises the cycle after the last operand handshake. An N-operand burst with no stalls finishes in N+1 cycles after start.
- Back-to-back bursts: start is accepted the cycle after the DONE->IDLE transition. No same-cycle restart.
- abort = 1 in any state: next state is IDLE with out_valid = 0, in_ready = 0, acc and flags cleared. abort takes priority over start, handshakes and out_ready. In IDLE, abort also blocks start.
- Async reset mid-burst: returns immediately to the reset values. A partial result is never presented.
- Operand count is exact: operands offered beyond len are not accepted (in_ready = 0 in DONE).

Test Plan:
- Basic accumulation: start with len = 3; operands 5, 7, 11 with no stalls -> out_valid in the 4th cycle after start, result = 23, ovf = 0, carry = 0.
- Stalls and backpressure: len = 2, operands 0x0100 and 0x0023 with 3 in_valid-low cycles between them; out_ready held low for 4 cycles -> result = 0x0123 held stable until out_ready, then IDLE.
- Signed overflow and wrap: len = 2, operands 0x7FFF and 0x0001 -> result 0x8000, ovf = 1, carry = 0.
- Sticky carry: len = 3, operands 0xFFFF, 0x0002, 0x0001 -> result 0x0002, carry = 1, ovf = 0.
- Zero-length burst: start with len = 0 -> out_valid the next cycle, result = 0, no operand accepted.
- Abort and reset: abort after 2 of 5 operands -> IDLE, no out_valid. A new burst of len = 1 with operand 9 -> result 9. Repeat with rst_n pulsed low mid-burst -> all outputs return to 0 immediately.
